iterative_multiplier: RTL and testbench

Multi-cycle shift-add multiplier that produces the 64-bit `multResult` consumed by the HI/LO split stage (`HI_out`/`LO_out`/`mulOut`) in the MIPS datapath. It handles signed and unsigned 32x32 multiplies, with optional accumulate or subtract against a 64-bit HI:LO operand for madd/msub-style instructions. The ALU control drives it through a start/busy/done handshake. The pipeline stalls on `busy`.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_finalize.sv | 29 ++
 rtl/iterative_multiplier.sv | 108 ++++++++++
 tb/tb_iterative_multiplier.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ITERS     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // accOp encodings; 2'b11 falls through to a plain product
  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_ADD  = 2'b01;
  localparam logic [1:0] ACC_SUB  = 2'b10;

endpackage

// File: rtl/mult_finalize.sv
// Final-cycle correction: restore product sign, then fold in HI:LO accumulate/subtract.
module mult_finalize
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic               i_neg,
  input  logic [1:0]         i_acc_op,
  input  logic [2*WIDTH-1:0] i_acc_in,
  output logic [2*WIDTH-1:0] o_result
);

  logic [2*WIDTH-1:0] w_prod_s;

  // Magnitude product back to two's complement when operand signs differed
  assign w_prod_s = i_neg ? (~i_prod + 1'b1) : i_prod;

  // Accumulate/subtract wraps modulo 2^(2*WIDTH) with no overflow flag
  always_comb begin
    o_result = w_prod_s;
    case (i_acc_op)
      ACC_ADD: o_result = i_acc_in + w_prod_s;
      ACC_SUB: o_result = i_acc_in - w_prod_s;
      default: o_result = w_prod_s;
    endcase
  end

endmodule

// File: rtl/iterative_multiplier.sv
// Radix-2 shift-add multiplier, one bit per cycle, start/busy/done handshake.
// Signed operands are reduced to magnitudes up front and the sign is reapplied
// in the FIX cycle, so the inner loop is a plain unsigned shift-add.
module iterative_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               signedOp,
  input  logic [1:0]         accOp,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2*WIDTH-1:0] accIn,
  output logic [2*WIDTH-1:0] multResult,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic [1:0]         r_acc_op;
  logic [2*WIDTH-1:0] r_acc_in;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_upper;
  logic [2*WIDTH-1:0] w_final;
  logic               w_accept;

  // |MIN_INT| still fits in WIDTH unsigned bits, so no extra magnitude bit is stored
  assign w_mag_a = (signedOp && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign w_mag_b = (signedOp && B[WIDTH-1]) ? (~B + 1'b1) : B;

  // Carry out of the upper-half add is kept and shifted into the MSB
  assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_upper = r_mplier[0] ? w_sum : {1'b0, r_prod[2*WIDTH-1:WIDTH]};

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  mult_finalize #(.WIDTH(WIDTH)) u_fin (
    .i_prod   (r_prod),
    .i_neg    (r_neg),
    .i_acc_op (r_acc_op),
    .i_acc_in (r_acc_in),
    .o_result (w_final)
  );

  // Control FSM plus datapath; all outputs registered
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_prod     <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_acc_op   <= ACC_NONE;
      r_acc_in   <= '0;
      multResult <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (w_accept) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= (A[WIDTH-1] ^ B[WIDTH-1]) & signedOp;
            r_acc_op <= accOp;
            r_acc_in <= accIn;
            r_prod   <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_prod   <= {w_upper, r_prod[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= FIX;
        end
        FIX: begin
          multResult <= w_final;
          busy       <= 1'b0;
          done       <= 1'b1;
          r_state    <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Scoreboard bench for iterative_multiplier: expected results are queued at
// issue time from a reference 64-bit multiply and popped when done pulses.
module tb_iterative_multiplier;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        signedOp = 1'b0;
  logic [1:0]  accOp = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [63:0] accIn = '0;
  logic [63:0] multResult;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  iterative_multiplier #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .signedOp(signedOp),
    .accOp(accOp), .A(A), .B(B), .accIn(accIn),
    .multResult(multResult), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic [1:0] acc,
                                        input logic [63:0] ai);
    logic [63:0] p;
    if (s) p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    else   p = {32'b0, a} * {32'b0, b};
    case (acc)
      2'b01:   return ai + p;
      2'b10:   return ai - p;
      default: return p;
    endcase
  endfunction

  // Drive a request (called away from the clock edge); sampled at the next edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [1:0] acc, input logic [63:0] ai);
    A = a; B = b; signedOp = s; accOp = acc; accIn = ai; start = 1'b1;
    sb.push_back(model(a, b, s, acc, ai));
  endtask

  // Follow one operation from its start edge to done; optionally pulse a
  // stray start with different operands after edge inject_at
  task automatic wait_result(input string name, input int inject_at);
    int cyc;
    bit seen, busy_ok, hold_ok;
    logic [63:0] prev, exp;
    @(posedge Clk); #1;
    start = 1'b0;
    cyc = 0; seen = 0; hold_ok = 1;
    busy_ok = (busy === 1'b1) && (done === 1'b0);
    prev = multResult;
    while (!seen && cyc < 60) begin
      if (cyc == inject_at) begin
        start = 1'b1; A = 32'h64; B = 32'h65; signedOp = 1'b0;
        accOp = 2'b01; accIn = 64'h1234;
      end else begin
        start = 1'b0;
      end
      @(posedge Clk); #1;
      cyc++;
      if (done === 1'b1) seen = 1;
      if (busy !== (cyc < 33)) busy_ok = 0;
      if (!seen && multResult !== prev) hold_ok = 0;
    end
    start = 1'b0;
    n_vec++;
    if (!seen || cyc != 33) begin
      n_err++; $display("FAIL %s latency: done after %0d edges (seen=%0d), required 33", name, cyc, seen);
    end
    n_vec++;
    if (!busy_ok) begin
      n_err++; $display("FAIL %s busy: busy profile wrong, required high E0..E32 and low at E33", name);
    end
    n_vec++;
    if (!hold_ok) begin
      n_err++; $display("FAIL %s hold: multResult changed before done, required %h held", name, prev);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    n_vec++;
    if (multResult !== exp) begin
      n_err++; $display("FAIL %s result: got %h required %h", name, multResult, exp);
    end
  endtask

  // Single isolated operation, also checking done is a one-cycle pulse
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [1:0] acc, input logic [63:0] ai);
    @(negedge Clk);
    issue(a, b, s, acc, ai);
    wait_result(name, -1);
    @(posedge Clk); #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s pulse: done=%b busy=%b after done cycle, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    #12;
    n_vec++;
    if (multResult !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_state: result=%h busy=%b done=%b, required 0 0 0", multResult, busy, done);
    end
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_unsigned;
    run_op("u_3x5", 32'd3, 32'd5, 1'b0, 2'b00, 64'd0);
    run_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00, 64'd0);
    run_op("u_zero", 32'd0, 32'hDEAD_BEEF, 1'b0, 2'b00, 64'd0);
  endtask

  task automatic test_signed;
    run_op("s_m1x1", 32'hFFFF_FFFF, 32'd1, 1'b1, 2'b00, 64'd0);
    run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 2'b00, 64'd0);
    run_op("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 2'b00, 64'd0);
    run_op("s_mixed", 32'hFFFF_FF85, 32'd1000, 1'b1, 2'b00, 64'd0);
  endtask

  task automatic test_accumulate;
    run_op("acc_add", 32'd2, 32'd3, 1'b1, 2'b01, 64'd10);
    run_op("acc_sub_wrap", 32'd1, 32'd1, 1'b0, 2'b10, 64'd0);
    run_op("acc_11_plain", 32'd7, 32'd6, 1'b0, 2'b11, 64'h5555);
    run_op("acc_sub_neg", 32'hFFFF_FFFE, 32'd4, 1'b1, 2'b10, 64'h1_0000_0000);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), {$urandom, $urandom});
    end
  endtask

  task automatic test_ignored_start;
    @(negedge Clk);
    issue(32'd7, 32'd9, 1'b0, 2'b00, 64'd0);
    wait_result("ignore_start", 5);
    @(negedge Clk);
  endtask

  task automatic test_back_to_back;
    @(negedge Clk);
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 2'b00, 64'd0);
    wait_result("b2b_first", -1);
    issue(32'hFFFF_FFF0, 32'd3, 1'b1, 2'b01, 64'd100);
    wait_result("b2b_second", -1);
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_run;
    bit no_done;
    @(negedge Clk);
    issue(32'd11, 32'd13, 1'b0, 2'b00, 64'd0);
    void'(sb.pop_back());
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (11) @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || multResult !== 64'd0) begin
      n_err++; $display("FAIL async_reset: busy=%b done=%b result=%h, required 0 0 0", busy, done, multResult);
    end
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    no_done = 1;
    repeat (40) begin
      @(posedge Clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) no_done = 0;
    end
    n_vec++;
    if (!no_done) begin
      n_err++; $display("FAIL reset_no_done: activity after reset, required idle");
    end
    run_op("post_reset", 32'd11, 32'd13, 1'b0, 2'b00, 64'd0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_accumulate();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
